// File: rtl/expr_stream_gen.sv
// Serial ASCII expression generator: streams "d (op d)*" one character per
// valid/ready transfer from a packed description of single-digit operands and +/* operators.
module expr_stream_gen #(
  parameter  int MAX_TERMS = 8,
  localparam int NW        = $clog2(MAX_TERMS + 1)
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   start,
  input  logic [NW-1:0]          nterms,
  input  logic [4*MAX_TERMS-1:0] digits,
  input  logic [MAX_TERMS-2:0]   ops,
  output logic [7:0]             out_char,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EMIT_D = 2'd1;
  localparam logic [1:0] S_EMIT_O = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [NW-1:0]          k_q, k_d;
  logic [NW-1:0]          nterms_q, nterms_d;
  logic [4*MAX_TERMS-1:0] digits_q, digits_d;
  logic [MAX_TERMS-2:0]   ops_q, ops_d;
  logic [7:0]             out_char_q, out_char_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;

  logic [MAX_TERMS-1:0]   digit_bad;
  logic                   cfg_bad;
  logic [NW-1:0]          k_inc;
  logic [3:0]             digit_next;
  logic                   op_cur;
  logic                   xfer;

  // Only operands that will actually be emitted must be valid BCD.
  for (genvar gi = 0; gi < MAX_TERMS; gi++) begin : g_digit_chk
    assign digit_bad[gi] = (NW'(gi) < nterms) && (digits[4*gi+3:4*gi] > 4'd9);
  end

  assign cfg_bad = (nterms == '0) || (nterms > NW'(MAX_TERMS)) || (|digit_bad);
  assign k_inc   = k_q + NW'(1);
  assign xfer    = out_valid_q & out_ready;

  always_comb begin
    digit_next = '0;
    op_cur     = 1'b0;
    for (int i = 0; i < MAX_TERMS; i++)
      if (k_inc == NW'(i)) digit_next = digits_q[4*i +: 4];
    for (int i = 0; i < MAX_TERMS - 1; i++)
      if (k_q == NW'(i)) op_cur = ops_q[i];
  end

  // Outputs are computed one step ahead so every port comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    nterms_d    = nterms_q;
    digits_d    = digits_q;
    ops_d       = ops_q;
    out_char_d  = out_char_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_bad) begin
            err_d = 1'b1;
          end else begin
            state_d     = S_EMIT_D;
            k_d         = '0;
            nterms_d    = nterms;
            digits_d    = digits;
            ops_d       = ops;
            out_char_d  = {4'h3, digits[3:0]};
            out_valid_d = 1'b1;
            out_last_d  = (nterms == NW'(1));
            busy_d      = 1'b1;
          end
        end
      end
      S_EMIT_D: begin
        if (xfer) begin
          if (k_q == nterms_q - NW'(1)) begin
            state_d     = S_IDLE;
            k_d         = '0;
            out_char_d  = 8'h00;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            busy_d      = 1'b0;
          end else begin
            state_d    = S_EMIT_O;
            out_char_d = op_cur ? 8'h2A : 8'h2B;
            out_last_d = 1'b0;
          end
        end
      end
      S_EMIT_O: begin
        if (xfer) begin
          state_d    = S_EMIT_D;
          k_d        = k_inc;
          out_char_d = {4'h3, digit_next};
          out_last_d = (k_inc == nterms_q - NW'(1));
        end
      end
      default: begin
        state_d     = S_IDLE;
        k_d         = '0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      nterms_q    <= '0;
      digits_q    <= '0;
      ops_q       <= '0;
      out_char_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      nterms_q    <= nterms_d;
      digits_q    <= digits_d;
      ops_q       <= ops_d;
      out_char_q  <= out_char_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign out_char  = out_char_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_expr_stream_gen.sv
// Bench for expr_stream_gen: directed and randomized expressions checked against
// a character-list model built from the expression description.
module tb_expr_stream_gen;
  localparam int MT = 8;
  localparam int NW = $clog2(MT + 1);

  logic            clk = 1'b0;
  logic            clr;
  logic            start;
  logic [NW-1:0]   nterms;
  logic [4*MT-1:0] digits;
  logic [MT-2:0]   ops;
  logic [7:0]      out_char;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic            busy;
  logic            err;

  int tests_run    = 0;
  int tests_failed = 0;

  expr_stream_gen #(.MAX_TERMS(MT)) dut (
    .clk(clk), .clr(clr), .start(start), .nterms(nterms), .digits(digits), .ops(ops),
    .out_char(out_char), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic bit legal_cfg(input int n, input logic [4*MT-1:0] d);
    if (n < 1 || n > MT) return 1'b0;
    for (int i = 0; i < n; i++)
      if (d[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  // mode 0: ready always high; 1: random ready; 2: ready low 3 cycles on the first operator.
  task automatic run_stream(input int n, input logic [4*MT-1:0] d, input logic [MT-2:0] o,
                            input int mode, input bit scramble, input string tag);
    logic [7:0] exp_q[$];
    int idx = 0, cycles = 0, stalls = 0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_char = 8'h00;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(8'h30 + {4'h0, d[4*i +: 4]});
      if (i < n - 1) exp_q.push_back(o[i] ? 8'h2A : 8'h2B);
    end
    nterms = NW'(n); digits = d; ops = o; start = 1'b1; out_ready = 1'b1;
    cyc();
    start = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s latency: valid=%b busy=%b, required 1 1", tag, out_valid, busy);
    end
    while (idx < exp_q.size() && cycles < 200) begin
      if (scramble) begin
        start = 1'($urandom); nterms = NW'($urandom); digits = $urandom; ops = (MT-1)'($urandom);
      end
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom);
        default: out_ready = !(idx == 1 && stalls < 3);
      endcase
      if (prev_stall) begin
        tests_run++;
        if (out_char !== prev_char) begin
          tests_failed++;
          $display("FAIL %s hold: char=%h, required %h", tag, out_char, prev_char);
        end
      end
      tests_run++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || out_char !== exp_q[idx] ||
          out_last !== (idx == exp_q.size() - 1)) begin
        tests_failed++;
        $display("FAIL %s char%0d: valid=%b busy=%b char=%h last=%b, required 1 1 %h %b", tag, idx,
                 out_valid, busy, out_char, out_last, exp_q[idx], idx == exp_q.size() - 1);
      end
      prev_stall = !out_ready;
      prev_char  = out_char;
      if (out_ready) idx++;
      else if (idx == 1) stalls++;
      cyc();
      cycles++;
    end
    start = 1'b0;
    tests_run++;
    if (cycles >= 200) begin
      tests_failed++;
      $display("FAIL %s timeout: %0d of %0d chars, required all", tag, idx, exp_q.size());
    end
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s end: valid=%b busy=%b last=%b, required 0 0 0", tag, out_valid, busy, out_last);
    end
    if (mode == 0) begin
      tests_run++;
      if (cycles != exp_q.size()) begin
        tests_failed++;
        $display("FAIL %s cycles: %0d, required %0d", tag, cycles, exp_q.size());
      end
    end
    if (mode == 2 && n > 1) begin
      tests_run++;
      if (stalls != 3) begin
        tests_failed++;
        $display("FAIL %s stalls: %0d, required 3", tag, stalls);
      end
    end
    $display("[TB] %s n=%0d chars=%0d cycles=%0d", tag, n, exp_q.size(), cycles);
  endtask

  task automatic test_err(input int n, input logic [4*MT-1:0] d, input string tag);
    nterms = NW'(n); digits = d; ops = '0; start = 1'b1; out_ready = 1'b1;
    cyc();
    start = 1'b0;
    tests_run++;
    if (err !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s err_pulse: err=%b valid=%b busy=%b, required 1 0 0", tag, err, out_valid, busy);
    end
    cyc();
    tests_run++;
    if (err !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s err_end: err=%b valid=%b busy=%b, required 0 0 0", tag, err, out_valid, busy);
    end
    $display("[TB] %s n=%0d digits=%h rejected", tag, n, d);
  endtask

  task automatic test_reset();
    clr = 1'b1; start = 1'b0; out_ready = 1'b0; nterms = '0; digits = '0; ops = '0;
    #12;
    tests_run++;
    if (out_char !== 8'h00 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset: char=%h valid=%b last=%b busy=%b err=%b, required all 0",
               out_char, out_valid, out_last, busy, err);
    end
    cyc();
    clr = 1'b0;
    cyc();
    $display("[TB] reset checked");
  endtask

  task automatic test_clr_abort();
    nterms = NW'(4); digits = 32'h0000_4321; ops = 7'b0000101; start = 1'b1; out_ready = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    #2 clr = 1'b1;
    #1;
    tests_run++;
    if (out_char !== 8'h00 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL clr_abort: char=%h valid=%b last=%b busy=%b err=%b, required all 0",
               out_char, out_valid, out_last, busy, err);
    end
    cyc();
    clr = 1'b0;
    $display("[TB] clr_abort checked");
    run_stream(2, 32'h0000_0000, 7'b0, 0, 1'b0, "after_clr");
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      int n;
      logic [4*MT-1:0] d;
      n = int'($urandom_range(0, 10));
      d = '0;
      for (int i = 0; i < MT; i++)
        d[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      if (legal_cfg(n, d)) run_stream(n, d, (MT-1)'($urandom), 1, t[0], "rand");
      else test_err(n, d, "rand_err");
    end
  endtask

  initial begin
    test_reset();
    run_stream(3, 32'h0000_0275, 7'b0000010, 0, 1'b0, "basic");
    run_stream(1, 32'h0000_0009, 7'b0, 0, 1'b0, "single");
    run_stream(3, 32'h0000_0275, 7'b0000010, 2, 1'b0, "backpressure");
    test_err(0, 32'h0000_0012, "nterms0");
    test_err(2, 32'h0000_00A0, "bad_term1");
    run_stream(2, 32'h00A0_0031, 7'b0000001, 0, 1'b0, "ignored_term5");
    test_clr_abort();
    run_stream(MT, 32'h9876_5432, 7'b1010101, 0, 1'b1, "start_ignored");
    run_stream(MT, 32'h1357_9024, 7'b0110011, 0, 1'b0, "back_to_back");
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
